obstacle_bank: RTL and testbench

Parametrised obstacle generator for FlappyBruin: drives `N_BARS` scrolling bars with independent gap heights from one shared LFSR. Scroll speed is picked from a three-level table indexed by score. The block has a run/frozen/restart state machine and emits per-bar wrap and pass pulses. It sits between the score/collision logic and the VGA bar renderer, and replaces single-bar generation.

---
 rtl/obstacle_pkg.sv | 10 +
 rtl/obstacle_bank_if.sv | 22 ++
 rtl/bar_tick_div.sv | 23 ++
 rtl/obstacle_bank.sv | 112 +++++++++++
 tb/tb_obstacle_bank.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared state type and helper math for the obstacle bank
package obstacle_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} obs_state_t;
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction
  function automatic logic [31:0] gap_clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
    return v <= lo ? lo : v >= hi ? hi : v;
  endfunction
endpackage

// File: rtl/obstacle_bank_if.sv
// obstacle_bank_if: game-control inputs and bar outputs of the obstacle bank
interface obstacle_bank_if #(
  parameter int N_BARS = 3,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int LFSR_W = 9
);
  logic                    game_start;
  logic                    lose;
  logic                    restart;
  logic [9:0]              score;
  logic [LFSR_W-1:0]       seed_in;
  logic [N_BARS*X_W-1:0]   x_bar;
  logic [N_BARS*Y_W-1:0]   y_gap;
  logic [N_BARS-1:0]       wraps;
  logic [N_BARS-1:0]       pass;
  logic [1:0]              level;
  modport master (output game_start, lose, restart, score, seed_in,
                  input  x_bar, y_gap, wraps, pass, level);
  modport slave  (input  game_start, lose, restart, score, seed_in,
                  output x_bar, y_gap, wraps, pass, level);
endinterface

// File: rtl/bar_tick_div.sv
// bar_tick_div: period counter that pulses tick on its last count and wraps to zero
module bar_tick_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  // >= keeps a freshly shortened period from overrunning
  always_comb begin
    tick  = en && cnt_q >= period - 1'b1;
    cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  end
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/obstacle_bank.sv
// obstacle_bank: scrolling bar generator with shared LFSR gaps and score-driven speed
module obstacle_bank
  import obstacle_pkg::*;
#(
  parameter int unsigned N_BARS     = 3,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned LFSR_W     = 9,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 9'h1AC,
  parameter int unsigned START_X    = 400,
  parameter int unsigned SPACING    = 240,
  parameter int unsigned GAP_MIN    = 120,
  parameter int unsigned GAP_MAX    = 360,
  parameter int unsigned SPEED_L1   = 300000,
  parameter int unsigned SPEED_L2   = 225000,
  parameter int unsigned SPEED_L3   = 150000,
  parameter int unsigned LVL2_SCORE = 5,
  parameter int unsigned LVL3_SCORE = 15,
  parameter int unsigned BIRD_X     = 100
) (
  input logic             clk_25MHz,
  input logic             reset,
  obstacle_bank_if.slave  bus
);
  localparam logic [X_W-1:0] X_WRAP = X_W'(N_BARS*SPACING - 1);
  localparam logic [X_W-1:0] X_BIRD = X_W'(BIRD_X);
  localparam logic [Y_W-1:0] Y_MID  = Y_W'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [9:0]     LVL2   = 10'(LVL2_SCORE);
  localparam logic [9:0]     LVL3   = 10'(LVL3_SCORE);

  obs_state_t        state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed, lfsr_step;
  logic [N_BARS-1:0] wrap_hit, pass_hit, wraps_q, pass_q;
  logic [Y_W-1:0]    gap_new;
  logic [31:0]       period;
  logic              tick, reload;

  // run/frozen/restart sequencing
  always_comb begin
    state_d = (state_q == IDLE && bus.game_start && !bus.lose) ? RUN :
              (state_q == RUN && bus.lose)                     ? FROZEN :
              (state_q == FROZEN && bus.restart)               ? IDLE : state_q;
    reload  = state_d == IDLE;
  end

  // speed level, period lookup and shared LFSR advance
  always_comb begin
    level_d   = bus.score < LVL2 ? 2'd0 : bus.score < LVL3 ? 2'd1 : 2'd2;
    period    = level_q == 2'd0 ? 32'(SPEED_L1) : level_q == 2'd1 ? 32'(SPEED_L2) : 32'(SPEED_L3);
    seed      = bus.seed_in == '0 ? LFSR_W'(1) : bus.seed_in;
    lfsr_step = LFSR_W'(lfsr_next(32'(lfsr_q), 32'(LFSR_TAPS)));
    lfsr_d    = state_q == IDLE ? seed : |wrap_hit ? (lfsr_step == '0 ? LFSR_W'(1) : lfsr_step) : lfsr_q;
    gap_new   = Y_W'(gap_clamp(32'(lfsr_q), GAP_MIN, GAP_MAX));
  end

  // the lose cycle is masked so a coinciding tick cannot move the bars
  bar_tick_div #(.W(32)) u_div (
    .clk    (clk_25MHz),
    .rst    (reset),
    .en     (state_q == RUN && !bus.lose),
    .clr    (reload),
    .period (period),
    .tick   (tick)
  );

  // shared control registers
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      lfsr_q  <= seed;
      wraps_q <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lfsr_q  <= lfsr_d;
      wraps_q <= wrap_hit;
      pass_q  <= pass_hit;
    end
  end

  for (genvar i = 0; i < N_BARS; i++) begin : g_bar
    localparam logic [X_W-1:0] X0 = X_W'(START_X + i*SPACING);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    assign wrap_hit[i] = tick && x_q == '0;
    assign pass_hit[i] = tick && x_q == X_BIRD;
    // scroll left, respawn at the far edge with a fresh gap
    always_comb begin
      x_d = reload ? X0 : wrap_hit[i] ? X_WRAP : tick ? x_q - 1'b1 : x_q;
      y_d = reload ? Y_MID : wrap_hit[i] ? gap_new : y_q;
    end
    // bar position and gap registers
    always_ff @(posedge clk_25MHz) begin
      if (reset) begin
        x_q <= X0;
        y_q <= Y_MID;
      end else begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
    assign bus.x_bar[i*X_W +: X_W] = x_q;
    assign bus.y_gap[i*Y_W +: Y_W] = y_q;
  end

  assign bus.wraps = wraps_q;
  assign bus.pass  = pass_q;
  assign bus.level = level_q;
endmodule

// File: tb/tb_obstacle_bank.sv
// tb_obstacle_bank: scoreboard bench comparing the obstacle bank against a behavioural model
module tb_obstacle_bank;
  localparam int NB = 3, XW = 10, YW = 9, LW = 9;
  localparam int SP1 = 4, SP2 = 3, SP3 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_bank_if #(.N_BARS(NB), .X_W(XW), .Y_W(YW), .LFSR_W(LW)) bus ();

  obstacle_bank #(.SPEED_L1(SP1), .SPEED_L2(SP2), .SPEED_L3(SP3)) dut (
    .clk_25MHz (clk),
    .reset     (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic [29:0] x;
    logic [26:0] y;
    logic [2:0]  w;
    logic [2:0]  p;
    logic [1:0]  lvl;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;

  int         m_st, m_cnt, m_lvl;
  int         m_x[NB], m_y[NB];
  logic [8:0] m_lfsr;
  logic [2:0] m_w, m_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] stepf(input logic [8:0] s);
    logic [8:0] t;
    logic fb;
    logic [8:0] r;
    t = 9'h1AC;
    fb = 1'b0;
    for (int b = 0; b < 9; b++) if (t[b]) fb = fb ^ s[b];
    r = {s[7:0], fb};
    return (r == 9'd0) ? 9'd1 : r;
  endfunction

  function automatic int clampf(input int v);
    if (v <= 120) return 120;
    if (v >= 360) return 360;
    return v;
  endfunction

  task automatic model_step();
    int per, nst;
    bit tk;
    logic [8:0] sd;
    exp_t e;
    sd = (bus.seed_in == 9'd0) ? 9'd1 : bus.seed_in;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_lvl = 0; m_lfsr = sd; m_w = 0; m_p = 0;
      for (int i = 0; i < NB; i++) begin m_x[i] = 400 + 240*i; m_y[i] = 240; end
    end else begin
      per = (m_lvl == 0) ? SP1 : (m_lvl == 1) ? SP2 : SP3;
      tk = (m_st == 1) && !bus.lose && (m_cnt >= per - 1);
      m_w = 0; m_p = 0;
      if (tk) for (int i = 0; i < NB; i++) begin
        if (m_x[i] == 100) m_p[i] = 1'b1;
        if (m_x[i] == 0) begin m_x[i] = 719; m_y[i] = clampf(int'(m_lfsr)); m_w[i] = 1'b1; end
        else m_x[i] = m_x[i] - 1;
      end
      if (m_w != 0) m_lfsr = stepf(m_lfsr);
      if (m_st == 0) m_lfsr = sd;
      if (m_st == 1 && !bus.lose) m_cnt = tk ? 0 : m_cnt + 1;
      case (m_st)
        0: nst = (bus.game_start && !bus.lose) ? 1 : 0;
        1: nst = bus.lose ? 2 : 1;
        default: nst = bus.restart ? 0 : 2;
      endcase
      if (nst == 0) begin
        m_cnt = 0;
        for (int i = 0; i < NB; i++) begin m_x[i] = 400 + 240*i; m_y[i] = 240; end
      end
      m_lvl = (bus.score < 5) ? 0 : (bus.score < 15) ? 1 : 2;
      m_st = nst;
    end
    e.x = {10'(m_x[2]), 10'(m_x[1]), 10'(m_x[0])};
    e.y = {9'(m_y[2]), 9'(m_y[1]), 9'(m_y[0])};
    e.w = m_w;
    e.p = m_p;
    e.lvl = 2'(m_lvl);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin : chk
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x_bar", bus.x_bar, e.x);
      check("y_gap", bus.y_gap, e.y);
      check("wraps", bus.wraps, e.w);
      check("pass", bus.pass, e.p);
      check("level", bus.level, e.lvl);
    end
  end

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset(input logic [8:0] s);
    rst = 1'b1;
    bus.seed_in = s;
    bus.game_start = 1'b0;
    bus.lose = 1'b0;
    bus.restart = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic wait_wrap(input int b, input string tag);
    for (int k = 0; k < 4000 && !bus.wraps[b]; k++) cyc();
    check(tag, bus.wraps[b], 1);
  endtask

  task automatic tick_gap(input int exp, input string tag);
    logic [9:0] prev;
    int n;
    prev = bus.x_bar[9:0];
    n = 0;
    while (bus.x_bar[9:0] == prev && n < 20) begin cyc(); n++; end
    prev = bus.x_bar[9:0];
    n = 0;
    do begin cyc(); n++; end while (bus.x_bar[9:0] == prev && n < 20);
    check(tag, n, exp);
  endtask

  initial begin : drive
    logic [29:0] hold;
    bit pass_seen;
    bus.score = 10'd0;
    do_reset(9'h0F5);
    check("rst_x", bus.x_bar, {10'd880, 10'd640, 10'd400});
    check("rst_y", bus.y_gap, {9'd240, 9'd240, 9'd240});
    check("rst_lvl", bus.level, 0);
    bus.game_start = 1'b1;
    cyc();
    cycles(3);
    check("x0_pre_tick", bus.x_bar[9:0], 400);
    cyc();
    check("x0_first_tick", bus.x_bar[9:0], 399);
    pass_seen = 1'b0;
    for (int k = 0; k < 4000 && !bus.wraps[0]; k++) begin
      cyc();
      if (bus.x_bar[9:0] == 10'd99 && !pass_seen) begin
        pass_seen = 1'b1;
        check("pass0_pulse", bus.pass[0], 1);
      end
    end
    check("pass0_seen", pass_seen, 1);
    check("wrap0_seen", bus.wraps[0], 1);
    check("wrap0_x", bus.x_bar[9:0], 719);
    check("wrap0_gap", bus.y_gap[8:0], 245);
    cyc();
    check("wrap0_one_cycle", bus.wraps[0], 0);
    wait_wrap(1, "wrap1_seen");
    check("wrap1_gap_after_step", bus.y_gap[17:9], 360);
    bus.score = 10'd4;
    cyc();
    check("lvl_score4", bus.level, 0);
    tick_gap(SP1, "gap_lvl0");
    bus.score = 10'd5;
    cyc();
    check("lvl_score5", bus.level, 1);
    tick_gap(SP2, "gap_lvl1");
    bus.score = 10'd15;
    cyc();
    check("lvl_score15", bus.level, 2);
    tick_gap(SP3, "gap_lvl2");
    for (int k = 0; k < 10 && m_cnt < SP3 - 1; k++) cyc();
    hold = {10'(m_x[2]), 10'(m_x[1]), 10'(m_x[0])};
    bus.lose = 1'b1;
    cyc();
    check("lose_tick_no_move", bus.x_bar, hold);
    cycles(1000);
    check("frozen_hold", bus.x_bar, hold);
    bus.lose = 1'b0;
    bus.game_start = 1'b0;
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    check("restart_x", bus.x_bar, {10'd880, 10'd640, 10'd400});
    check("restart_y", bus.y_gap, {9'd240, 9'd240, 9'd240});
    check("restart_lvl", bus.level, 2);
    cycles(3);
    do_reset(9'h010);
    bus.game_start = 1'b1;
    wait_wrap(0, "seed16_wrap");
    check("seed16_gap", bus.y_gap[8:0], 120);
    do_reset(9'h1F0);
    bus.game_start = 1'b1;
    wait_wrap(0, "seed496_wrap");
    check("seed496_gap", bus.y_gap[8:0], 360);
    do_reset(9'h000);
    bus.game_start = 1'b1;
    wait_wrap(0, "seed0_wrap");
    check("seed0_gap", bus.y_gap[8:0], 120);
    cycles(37);
    rst = 1'b1;
    cyc();
    check("midrun_rst_x", bus.x_bar, {10'd880, 10'd640, 10'd400});
    check("midrun_rst_y", bus.y_gap, {9'd240, 9'd240, 9'd240});
    check("midrun_rst_lvl", bus.level, 0);
    check("midrun_rst_wraps", bus.wraps, 0);
    rst = 1'b0;
    bus.game_start = 1'b0;
    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
